// File: rtl/usb_txn_sched.sv
// usb_txn_sched: host-side transaction scheduler. Two requesters share one
// protocol engine; round-robin grant, token phase then data phase, bounded
// retries, per-phase watchdog, status/read data returned on a done pulse.
module usb_txn_sched #(
  parameter int MAX_RETRY   = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req0_dir,
  input  logic [63:0] req0_wdata,
  input  logic        req1,
  input  logic        req1_dir,
  input  logic [63:0] req1_wdata,
  output logic        done0,
  output logic        done1,
  output logic        ok,
  output logic [63:0] rdata,
  output logic [3:0]  retries,
  output logic        busy,
  output logic [2:0]  msg_type,
  output logic [63:0] protocol_din,
  input  logic        protocol_free,
  input  logic [63:0] protocol_dout,
  input  logic        timeout
);

  localparam int WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TOK_ISSUE = 3'd1;
  localparam logic [2:0] S_TOK_WAIT  = 3'd2;
  localparam logic [2:0] S_DAT_ISSUE = 3'd3;
  localparam logic [2:0] S_DAT_WAIT  = 3'd4;
  localparam logic [2:0] S_FAIL_CHK  = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  logic [2:0]     state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           dir_q, dir_d;
  logic           last_gnt_q, last_gnt_d;
  logic [3:0]     retry_q, retry_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           ok_q, ok_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [63:0]    din_q, din_d;
  logic           pick;

  // Tie goes to the requester that did not win last time.
  assign pick = (req0 && req1) ? ~last_gnt_q : req1;

  // Next-state and datapath updates for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    dir_d      = dir_q;
    last_gnt_d = last_gnt_q;
    retry_d    = retry_q;
    wd_d       = wd_q;
    ok_d       = ok_q;
    rdata_d    = rdata_q;
    din_d      = din_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d      = pick;
          dir_d      = pick ? req1_dir : req0_dir;
          din_d      = pick ? req1_wdata : req0_wdata;
          last_gnt_d = pick;
          retry_d    = 4'd0;
          ok_d       = 1'b0;
          state_d    = S_TOK_ISSUE;
        end
      end
      S_TOK_ISSUE, S_DAT_ISSUE: begin
        if (protocol_free) begin
          wd_d    = '0;
          state_d = (state_q == S_TOK_ISSUE) ? S_TOK_WAIT : S_DAT_WAIT;
        end
      end
      S_TOK_WAIT, S_DAT_WAIT: begin
        if (wd_q != '1) wd_d = wd_q + 1'b1;
        // wd_q==0 marks the entry cycle, where the engine may still be
        // showing free from the acceptance; the counter never wraps back.
        if (wd_q != '0) begin
          if (timeout || (wd_q == WD_LAST)) begin
            state_d = S_FAIL_CHK;
          end else if (protocol_free) begin
            if (state_q == S_TOK_WAIT) begin
              state_d = S_DAT_ISSUE;
            end else begin
              state_d = S_RESP;
              ok_d    = 1'b1;
              if (dir_q) rdata_d = protocol_dout;
            end
          end
        end
      end
      S_FAIL_CHK: begin
        if (retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 4'd1;
          state_d = S_TOK_ISSUE;
        end else begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      dir_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      retry_q    <= 4'd0;
      wd_q       <= '0;
      ok_q       <= 1'b0;
      rdata_q    <= 64'd0;
      din_q      <= 64'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      dir_q      <= dir_d;
      last_gnt_q <= last_gnt_d;
      retry_q    <= retry_d;
      wd_q       <= wd_d;
      ok_q       <= ok_d;
      rdata_q    <= rdata_d;
      din_q      <= din_d;
    end
  end

  // Moore decode of the engine command so it is stable for the whole dwell.
  always_comb begin
    msg_type = 3'b000;
    case (state_q)
      S_TOK_ISSUE: msg_type = dir_q ? 3'b001 : 3'b010;
      S_DAT_ISSUE: msg_type = dir_q ? 3'b100 : 3'b011;
      default:     msg_type = 3'b000;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done0        = (state_q == S_RESP) && !gnt_q;
  assign done1        = (state_q == S_RESP) && gnt_q;
  assign ok           = (state_q == S_RESP) && ok_q;
  assign retries      = retry_q;
  assign rdata        = rdata_q;
  assign protocol_din = din_q;

endmodule

// File: tb/tb_usb_txn_sched.sv
// Bench for usb_txn_sched: a behavioural engine drives free/timeout/dout
// from a per-attempt fault plan; the expected outcome of each transaction is
// derived from the plan (first clean attempt, retry limit, round-robin order).
module tb_usb_txn_sched;
  localparam int MAXR = 3;
  localparam int WDOG = 16;

  logic        clk;
  logic        rst;
  logic        req0, req0_dir, req1, req1_dir;
  logic [63:0] req0_wdata, req1_wdata;
  logic        done0, done1, ok, busy;
  logic [63:0] rdata, protocol_din, protocol_dout;
  logic [3:0]  retries;
  logic [2:0]  msg_type;
  logic        protocol_free, timeout;

  usb_txn_sched #(.MAX_RETRY(MAXR), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_dir(req0_dir), .req0_wdata(req0_wdata),
    .req1(req1), .req1_dir(req1_dir), .req1_wdata(req1_wdata),
    .done0(done0), .done1(done1), .ok(ok), .rdata(rdata), .retries(retries),
    .busy(busy), .msg_type(msg_type), .protocol_din(protocol_din),
    .protocol_free(protocol_free), .protocol_dout(protocol_dout), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-requester configuration; plan codes per attempt:
  // 0 clean, 1 timeout in token wait, 2 timeout in data wait,
  // 3 engine hangs in token wait, 4 engine hangs in data wait.
  bit          cfg_dir [2];
  logic [63:0] cfg_wd  [2];
  logic [63:0] cfg_dout[2];
  int          cfg_lt  [2];
  int          cfg_ld  [2];
  int          cfg_pl  [2][16];

  // Configuration of the transaction currently expected to be granted.
  bit          cur_dir;
  logic [63:0] cur_wd, cur_dout;
  int          cur_lt, cur_ld;
  int          cur_pl[16];

  // Reference state.
  bit          m_last;
  logic [63:0] m_rdata;
  logic [2:0]  exp_log[$];

  // Engine state (written only by the engine process).
  logic [2:0]  eng_log[$];
  int          att, e_cnt, e_lat, hang_last;
  bit          e_busy, e_to, e_hang;
  logic [2:0]  e_msg;

  initial begin
    #900000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  // Behavioural protocol engine, acting on the falling edge.
  initial begin
    int  code;
    bit  tokph;
    protocol_free = 1'b1; timeout = 1'b0; protocol_dout = '0;
    att = 0; e_busy = 0; e_cnt = 0; e_lat = 0; hang_last = 0;
    e_to = 0; e_hang = 0; e_msg = '0;
    forever begin
      @(negedge clk);
      timeout = 1'b0;
      if (busy !== 1'b1) begin
        att = 0;
        if (e_busy) begin e_busy = 0; protocol_free = 1'b1; end
      end
      if (e_busy) begin
        e_cnt++;
        if (e_hang) begin
          if (msg_type != 3'b000) begin
            e_busy = 0; protocol_free = 1'b1; hang_last = e_cnt;
          end else protocol_free = (e_cnt == 1);
        end else if (e_cnt == 1) protocol_free = 1'b1;
        else if (e_to && e_cnt == 2) begin
          timeout = 1'b1; protocol_free = 1'b1; e_busy = 0;
        end else if (e_cnt < e_lat + 2) protocol_free = 1'b0;
        else begin
          protocol_free = 1'b1; e_busy = 0;
          if (e_msg == 3'b100) protocol_dout = cur_dout;
        end
      end
      if (!e_busy && protocol_free && msg_type != 3'b000) begin
        e_busy = 1; e_cnt = 0; e_msg = msg_type;
        tokph = (msg_type == 3'b001 || msg_type == 3'b010);
        if (tokph) begin
          if (att == 0) eng_log.delete();
          att++;
        end
        eng_log.push_back(msg_type);
        code   = (att > 0) ? cur_pl[att-1] : 0;
        e_to   = tokph ? (code == 1) : (code == 2);
        e_hang = tokph ? (code == 3) : (code == 4);
        e_lat  = tokph ? cur_lt : cur_ld;
        if (e_msg == 3'b100) protocol_dout = ~cur_dout;
        timeout = ($urandom_range(0, 3) == 0);  // must be ignored while issuing
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int r, input bit d, input logic [63:0] wd, input logic [63:0] dout,
                     input int lt, input int ld);
    cfg_dir[r] = d; cfg_wd[r] = wd; cfg_dout[r] = dout; cfg_lt[r] = lt; cfg_ld[r] = ld;
    for (int a = 0; a < 16; a++) cfg_pl[r][a] = 0;
  endtask

  task automatic rand_cfg(input int r);
    int x;
    cfg(r, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
        $urandom_range(0, 6), $urandom_range(0, 6));
    for (int a = 0; a <= MAXR; a++) begin
      x = $urandom_range(0, 9);
      cfg_pl[r][a] = (x < 5) ? 0 : (x < 7) ? 1 : (x < 9) ? 2 : 3 + $urandom_range(0, 1);
    end
  endtask

  task automatic load(input bit w);
    cur_dir = cfg_dir[w]; cur_wd = cfg_wd[w]; cur_dout = cfg_dout[w];
    cur_lt = cfg_lt[w]; cur_ld = cfg_ld[w];
    for (int a = 0; a < 16; a++) cur_pl[a] = cfg_pl[w][a];
  endtask

  task automatic wait_done(output bit found);
    found = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done0 === 1'b1 || done1 === 1'b1) begin found = 1; break; end
    end
  endtask

  // Run cnt grants with the requesters in mask held, checking each outcome.
  task automatic serve(input bit [1:0] mask, input int cnt);
    bit w, found, eok;
    int first_ok, eret;
    logic [2:0] tok, dat;
    req0_dir = cfg_dir[0]; req0_wdata = cfg_wd[0];
    req1_dir = cfg_dir[1]; req1_wdata = cfg_wd[1];
    w = (mask == 2'b11) ? ~m_last : mask[1];
    load(w);
    req0 = mask[0]; req1 = mask[1];
    for (int k = 0; k < cnt; k++) begin
      wait_done(found);
      chk("done_seen", 64'(found), 64'd1);
      chk("done0", 64'(done0), 64'(!w));
      chk("done1", 64'(done1), 64'(w));
      first_ok = -1;
      for (int a = 0; a <= MAXR; a++) if (first_ok < 0 && cur_pl[a] == 0) first_ok = a;
      eok  = (first_ok >= 0);
      eret = eok ? first_ok : MAXR;
      tok  = cur_dir ? 3'b001 : 3'b010;
      dat  = cur_dir ? 3'b100 : 3'b011;
      exp_log.delete();
      for (int a = 0; a <= eret; a++) begin
        exp_log.push_back(tok);
        if (cur_pl[a] != 1 && cur_pl[a] != 3) exp_log.push_back(dat);
      end
      if (eok && cur_dir) m_rdata = cur_dout;
      chk("ok", 64'(ok), 64'(eok));
      chk("retries", 64'(retries), 64'(eret));
      chk("rdata", rdata, m_rdata);
      chk("protocol_din", protocol_din, cur_wd);
      chk("msg_count", 64'(eng_log.size()), 64'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < eng_log.size(); i++)
        chk($sformatf("msg[%0d]", i), 64'(eng_log[i]), 64'(exp_log[i]));
      m_last = w;
      if (k + 1 < cnt) begin
        w = (mask == 2'b11) ? ~w : w;
        load(w);
      end
      @(negedge clk);
      chk("bubble_busy", 64'(busy), 64'd0);
      chk("done_single", 64'(done0 | done1), 64'd0);
      if (k + 1 == cnt) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req0_dir = 1'b0; req1_dir = 1'b0;
    req0_wdata = '0; req1_wdata = '0;
    m_last = 1'b1; m_rdata = '0;
    cfg(0, 1'b0, '0, '0, 0, 0); cfg(1, 1'b0, '0, '0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_msg", 64'(msg_type), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_ok", 64'(ok), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_retries", 64'(retries), 64'd0);
    chk("rst_din", protocol_din, 64'd0);
    rst = 1'b0;

    // Both held from reset: grants alternate 0,1,0,1.
    cfg(0, 1'b0, 64'hAAAA_0000_5555_1111, '0, 1, 2);
    cfg(1, 1'b1, 64'h1234, 64'hCAFE_F00D_DEAD_BEEF, 2, 1);
    serve(2'b11, 4);

    // Plain OUT on requester 0.
    cfg(0, 1'b0, 64'hF77DB57B7D5D7F53, '0, 4, 4);
    serve(2'b01, 1);

    // IN on requester 1.
    cfg(1, 1'b1, 64'h0, 64'h0123456789ABCDEF, 3, 3);
    serve(2'b10, 1);

    // Timeout in first data wait, clean retry.
    cfg(0, 1'b0, 64'h0BAD_CAFE_0000_0003, '0, 2, 2);
    cfg_pl[0][0] = 2;
    serve(2'b01, 1);

    // Timeout on every attempt: exhausts retries, rdata untouched.
    cfg(0, 1'b0, 64'h4444_0000_4444_0000, '0, 1, 1);
    for (int a = 0; a < 16; a++) cfg_pl[0][a] = 2;
    serve(2'b01, 1);

    // Engine never re-raises free in token wait: watchdog forces a retry.
    cfg(0, 1'b0, 64'h5A5A, '0, 1, 1);
    cfg_pl[0][0] = 3;
    serve(2'b01, 1);
    chk("wdog_dwell", 64'(hang_last), 64'(WDOG + 2));

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      int mk;
      rand_cfg(0); rand_cfg(1);
      mk = $urandom_range(1, 3);
      serve(2'(mk), (mk == 3) ? 2 : 1);
    end

    // Reset during data wait abandons the transaction.
    cfg(0, 1'b0, 64'h7777_8888_9999_AAAA, '0, 1, 10);
    load(1'b0);
    req0_dir = 1'b0; req0_wdata = cfg_wd[0];
    req0 = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (msg_type == 3'b011) seen = 1;
    end
    chk("dat_issue_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("rst_mid_msg", 64'(msg_type), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done0 | done1), 64'd0);
    chk("rst_mid_din", protocol_din, 64'd0);
    rst = 1'b0;
    m_last = 1'b1; m_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done0 | done1), 64'd0);
    end
    cfg(0, 1'b0, 64'h1357_9BDF_2468_ACE0, '0, 2, 2);
    serve(2'b01, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
